mips_control_fsm: RTL and testbench

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

---
 rtl/mips_ctrl_pkg.sv | 94 +++++++++
 rtl/mips_ctrl_decode.sv | 53 +++++
 rtl/mips_control_fsm.sv | 249 ++++++++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
//   - FSM state encoding and decoded instruction classes
//   - opcode / funct constants, ALU operation codes
//   - microcode word field positions, PC mux selects and a packing helper
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } ctrlState;

    typedef enum logic [3:0] {
        ClsRAlu,
        ClsImm,
        ClsLoad,
        ClsStore,
        ClsBeq,
        ClsBne,
        ClsJump,
        ClsJr,
        ClsHalt,
        ClsIllegal
    } instrClass;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpHalt  = 6'h3F;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluAnd = 4'd2;
    localparam logic [3:0] AluOr  = 4'd3;
    localparam logic [3:0] AluSlt = 4'd4;

    // PC mux selects
    localparam logic [1:0] PcJump   = 2'b00;
    localparam logic [1:0] PcInc    = 2'b01;
    localparam logic [1:0] PcBranch = 2'b10;
    localparam logic [1:0] PcReg    = 2'b11;

    // Microcode field positions
    localparam int unsigned McPcMsb  = 10;
    localparam int unsigned McPcLsb  = 9;
    localparam int unsigned McWbAlu  = 8;
    localparam int unsigned McAluB   = 7;
    localparam int unsigned McDestRd = 6;
    localparam int unsigned McAluMsb = 5;
    localparam int unsigned McAluLsb = 2;
    localparam int unsigned McRegWr  = 1;
    localparam int unsigned McDr     = 0;
    localparam int unsigned McWidth  = 11;

    function automatic logic [McWidth-1:0] mcPack(
        input logic [1:0] pcSel,
        input logic       wbAlu,
        input logic       aluImm,
        input logic       destRd,
        input logic [3:0] aluOp,
        input logic       regWr,
        input logic       dr
    );
        logic [McWidth-1:0] mc;
        mc                    = '0;
        mc[McPcMsb:McPcLsb]   = pcSel;
        mc[McWbAlu]           = wbAlu;
        mc[McAluB]            = aluImm;
        mc[McDestRd]          = destRd;
        mc[McAluMsb:McAluLsb] = aluOp;
        mc[McRegWr]           = regWr;
        mc[McDr]              = dr;
        return mc;
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct decoder for the MIPS control unit.
//   iOpcode  : instruction[31:26]
//   iFunct   : instruction[5:0]
//   oClass   : instruction class (instrClass encoding)
//   oAluOp   : ALU operation for the instruction
//   oAluImm  : ALU-B operand is the immediate
//   oDestRd  : destination register is rd (R-type) rather than rt
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] iOpcode,
    input  logic [5:0] iFunct,
    output logic [3:0] oClass,
    output logic [3:0] oAluOp,
    output logic       oAluImm,
    output logic       oDestRd
);

    instrClass cls;

    always_comb begin
        cls     = ClsIllegal;
        oAluOp  = AluAdd;
        oAluImm = 1'b0;
        oDestRd = 1'b0;
        case (iOpcode)
            OpRType: begin
                oDestRd = 1'b1;
                case (iFunct)
                    FnAdd:   begin cls = ClsRAlu; oAluOp = AluAdd; end
                    FnSub:   begin cls = ClsRAlu; oAluOp = AluSub; end
                    FnAnd:   begin cls = ClsRAlu; oAluOp = AluAnd; end
                    FnOr:    begin cls = ClsRAlu; oAluOp = AluOr;  end
                    FnSlt:   begin cls = ClsRAlu; oAluOp = AluSlt; end
                    FnJr:    cls = ClsJr;
                    default: cls = ClsIllegal;
                endcase
            end
            OpAddi:  begin cls = ClsImm;   oAluImm = 1'b1; oAluOp = AluAdd; end
            OpOri:   begin cls = ClsImm;   oAluImm = 1'b1; oAluOp = AluOr;  end
            OpLw:    begin cls = ClsLoad;  oAluImm = 1'b1; oAluOp = AluAdd; end
            OpSw:    begin cls = ClsStore; oAluImm = 1'b1; oAluOp = AluAdd; end
            OpBeq:   cls = ClsBeq;
            OpBne:   cls = ClsBne;
            OpJ:     cls = ClsJump;
            OpHalt:  cls = ClsHalt;
            default: cls = ClsIllegal;
        endcase
    end

    assign oClass = cls;

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM (Moore, all outputs registered).
//   CLK, RST      : clock, asynchronous active-low reset
//   iOpcode/iFunct: instruction fields from the datapath IR
//   iEqual        : SR1 == SR2 for branch resolution
//   oMicrocode    : datapath control word (fields in mips_ctrl_pkg)
//   oPC_Write, oIR_Write, oCS, oWE : PC load, IR latch, memory select / write
//   oRetire, oIllegal, oHalted     : completion pulse, illegal pulse, sticky halt
//   oRetireCount  : retired-instruction counter, only when MIPS_CTRL_PERF_CNT_EN
//                   is defined
// MEM_WAIT (1..15) sets how many cycles the MEM state holds oCS.
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  iOpcode,
    input  logic [5:0]  iFunct,
    input  logic        iEqual,
    output logic [10:0] oMicrocode,
    output logic        oPC_Write,
    output logic        oIR_Write,
    output logic        oCS,
    output logic        oWE,
    output logic        oRetire,
    output logic        oIllegal,
    output logic        oHalted
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] oRetireCount
`endif
);

    ctrlState   stateQ, stateD;
    logic       pendQ;
    logic [3:0] cntQ, cntD;

    logic [3:0] decClsRaw;
    instrClass  decCls;
    logic [3:0] decAluOp;
    logic       decAluImm, decDestRd;

    instrClass  clsQ;
    logic [3:0] aluOpQ;
    logic       aluImmQ, destRdQ;

    instrClass  curCls;
    logic [3:0] curAluOp;
    logic       curAluImm, curDestRd;

    logic [10:0] mcD;
    logic        pcWrD, irWrD, csD, weD, retireD, illegalD, haltedD;

    mips_ctrl_decode uDecode (
        .iOpcode (iOpcode),
        .iFunct  (iFunct),
        .oClass  (decClsRaw),
        .oAluOp  (decAluOp),
        .oAluImm (decAluImm),
        .oDestRd (decDestRd)
    );

    assign decCls = instrClass'(decClsRaw);

    // State register. pendQ marks the cycle between reset release and the
    // first FETCH so that FETCH outputs appear on the first edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateQ <= StFetch;
            pendQ  <= 1'b1;
            cntQ   <= 4'd0;
        end else begin
            stateQ <= stateD;
            pendQ  <= 1'b0;
            cntQ   <= cntD;
        end
    end

    // Decode results are captured on leaving DECODE and used for later states.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clsQ    <= ClsIllegal;
            aluOpQ  <= AluAdd;
            aluImmQ <= 1'b0;
            destRdQ <= 1'b0;
        end else if (stateQ == StDecode) begin
            clsQ    <= decCls;
            aluOpQ  <= decAluOp;
            aluImmQ <= decAluImm;
            destRdQ <= decDestRd;
        end
    end

    // Outputs for EXEC are computed while still in DECODE, so use live decode there.
    always_comb begin
        if (stateQ == StDecode) begin
            curCls    = decCls;
            curAluOp  = decAluOp;
            curAluImm = decAluImm;
            curDestRd = decDestRd;
        end else begin
            curCls    = clsQ;
            curAluOp  = aluOpQ;
            curAluImm = aluImmQ;
            curDestRd = destRdQ;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        if (pendQ) begin
            stateD = StFetch;
        end else begin
            case (stateQ)
                StFetch:  stateD = StDecode;
                StDecode: stateD = (decCls == ClsHalt) ? StHalt : StExec;
                StExec: begin
                    case (clsQ)
                        ClsRAlu, ClsImm: stateD = StWb;
                        ClsLoad, ClsStore: begin
                            stateD = StMem;
                            cntD   = 4'(MEM_WAIT - 1);
                        end
                        default: stateD = StFetch;
                    endcase
                end
                StMem: begin
                    if (cntQ == 4'd0) begin
                        stateD = StWb;
                    end else begin
                        cntD = cntQ - 4'd1;
                    end
                end
                StWb:    stateD = StFetch;
                StHalt:  stateD = StHalt;
                default: stateD = StFetch;
            endcase
        end
    end

    // Output logic: values for the state being entered, registered below.
    always_comb begin
        mcD      = '0;
        pcWrD    = 1'b0;
        irWrD    = 1'b0;
        csD      = 1'b0;
        weD      = 1'b0;
        retireD  = 1'b0;
        illegalD = 1'b0;
        haltedD  = 1'b0;
        case (stateD)
            StFetch: begin
                csD   = 1'b1;
                irWrD = 1'b1;
            end
            StExec: begin
                case (curCls)
                    ClsRAlu, ClsImm: begin
                        mcD = mcPack(PcJump, 1'b1, curAluImm, curDestRd, curAluOp, 1'b0, 1'b0);
                    end
                    ClsLoad, ClsStore: begin
                        mcD = mcPack(PcJump, 1'b0, 1'b1, 1'b0, AluAdd, 1'b0, 1'b0);
                    end
                    ClsBeq, ClsBne: begin
                        // BNE inverts the sense of the equality compare
                        mcD = mcPack((iEqual ^ (curCls == ClsBne)) ? PcBranch : PcInc,
                                     1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                        pcWrD   = 1'b1;
                        retireD = 1'b1;
                    end
                    ClsJump: begin
                        mcD     = mcPack(PcJump, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                        pcWrD   = 1'b1;
                        retireD = 1'b1;
                    end
                    ClsJr: begin
                        mcD     = mcPack(PcReg, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                        pcWrD   = 1'b1;
                        retireD = 1'b1;
                    end
                    default: begin
                        mcD      = mcPack(PcInc, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                        pcWrD    = 1'b1;
                        retireD  = 1'b1;
                        illegalD = 1'b1;
                    end
                endcase
            end
            StMem: begin
                // Address operands held stable for the whole access
                mcD = mcPack(PcJump, 1'b0, 1'b1, 1'b0, AluAdd, 1'b0, curCls == ClsLoad);
                csD = 1'b1;
                weD = (curCls == ClsStore);
            end
            StWb: begin
                if (curCls == ClsStore) begin
                    mcD = mcPack(PcInc, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
                end else begin
                    mcD = mcPack(PcInc, curCls != ClsLoad, curAluImm, curDestRd, curAluOp,
                                 1'b1, 1'b0);
                end
                pcWrD   = 1'b1;
                retireD = 1'b1;
            end
            StHalt:  haltedD = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            oMicrocode <= '0;
            oPC_Write  <= 1'b0;
            oIR_Write  <= 1'b0;
            oCS        <= 1'b0;
            oWE        <= 1'b0;
            oRetire    <= 1'b0;
            oIllegal   <= 1'b0;
            oHalted    <= 1'b0;
        end else begin
            oMicrocode <= mcD;
            oPC_Write  <= pcWrD;
            oIR_Write  <= irWrD;
            oCS        <= csD;
            oWE        <= weD;
            oRetire    <= retireD;
            oIllegal   <= illegalD;
            oHalted    <= haltedD;
        end
    end

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] retireCntQ;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            retireCntQ <= 32'd0;
        end else if (oRetire) begin
            retireCntQ <= retireCntQ + 32'd1;
        end
    end

    assign oRetireCount = retireCntQ;
`endif

endmodule

// File: tb/tb_mips_control_fsm.sv
module tb_mips_control_fsm;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, SLT = 4'd4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [5:0]  iOpcode = 6'h00;
    logic [5:0]  iFunct = 6'h00;
    logic        iEqual = 1'b0;
    logic [10:0] oMicrocode;
    logic        oPC_Write, oIR_Write, oCS, oWE, oRetire, oIllegal, oHalted;
`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [31:0] retireCount;
`endif

    int nAsserts = 0;
    int nFail = 0;
    logic [17:0] sb[$];

    mips_control_fsm #(.MEM_WAIT(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .iOpcode    (iOpcode),
        .iFunct     (iFunct),
        .iEqual     (iEqual),
        .oMicrocode (oMicrocode),
        .oPC_Write  (oPC_Write),
        .oIR_Write  (oIR_Write),
        .oCS        (oCS),
        .oWE        (oWE),
        .oRetire    (oRetire),
        .oIllegal   (oIllegal),
        .oHalted    (oHalted)
`ifdef MIPS_CTRL_PERF_CNT_EN
        ,
        .oRetireCount (retireCount)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [10:0] mc(input logic [1:0] pc, input logic wb, input logic b,
                                       input logic dst, input logic [3:0] alu,
                                       input logic rw, input logic dr);
        return {pc, wb, b, dst, alu, rw, dr};
    endfunction

    // {microcode, pcWrite, irWrite, cs, we, retire, illegal, halted}
    function automatic logic [17:0] ev(input logic [10:0] m, input logic pcw, input logic irw,
                                       input logic cs, input logic we, input logic ret,
                                       input logic ill, input logic hlt);
        return {m, pcw, irw, cs, we, ret, ill, hlt};
    endfunction

    task automatic check(input string tag, input logic [17:0] e);
        logic [17:0] obs;
        obs = {oMicrocode, oPC_Write, oIR_Write, oCS, oWE, oRetire, oIllegal, oHalted};
        nAsserts++;
        assert (obs === e) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // One cycle per queued entry; each pop is compared against the DUT.
    task automatic drain(input string tag);
        logic [17:0] e;
        int idx;
        idx = 0;
        while (sb.size() > 0) begin
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d]", tag, idx), e);
            idx++;
        end
    endtask

    task automatic setIn(input logic [5:0] op, input logic [5:0] fn, input logic eq);
        iOpcode = op;
        iFunct  = fn;
        iEqual  = eq;
    endtask

    task automatic pushFD();
        sb.push_back(ev(11'd0, 0, 1, 1, 0, 0, 0, 0));
        sb.push_back(ev(11'd0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic pushAlu(input logic imm, input logic [3:0] alu);
        pushFD();
        sb.push_back(ev(mc(2'b00, 1, imm, !imm, alu, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        sb.push_back(ev(mc(2'b01, 1, imm, !imm, alu, 1, 0), 1, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic pushOneExec(input logic [1:0] pc, input logic ill);
        pushFD();
        sb.push_back(ev(mc(pc, 0, 0, 0, 4'd0, 0, 0), 1, 0, 0, 0, 1, ill, 0));
    endtask

    task automatic pushMem(input logic load, input int cycles);
        for (int i = 0; i < cycles; i++)
            sb.push_back(ev(mc(2'b00, 0, 1, 0, ADD, 0, load), 0, 0, 1, !load, 0, 0, 0));
    endtask

    task automatic pushLoadStore(input logic load);
        pushFD();
        sb.push_back(ev(mc(2'b00, 0, 1, 0, ADD, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        pushMem(load, 3);
        if (load)
            sb.push_back(ev(mc(2'b01, 0, 1, 0, ADD, 1, 0), 1, 0, 0, 0, 1, 0, 0));
        else
            sb.push_back(ev(mc(2'b01, 0, 0, 0, 4'd0, 0, 0), 1, 0, 0, 0, 1, 0, 0));
    endtask

    initial begin
        // Reset held across clock edges: everything low
        repeat (2) @(posedge CLK);
        #1;
        check("reset", 18'd0);
        #3 RST = 1'b1;

        setIn(6'h00, 6'h20, 0); pushAlu(0, ADD); drain("add");
        setIn(6'h00, 6'h22, 0); pushAlu(0, SUB); drain("sub");
        setIn(6'h00, 6'h24, 0); pushAlu(0, AND); drain("and");
        setIn(6'h00, 6'h25, 0); pushAlu(0, OR);  drain("or");
        setIn(6'h00, 6'h2A, 0); pushAlu(0, SLT); drain("slt");
        setIn(6'h08, 6'h15, 0); pushAlu(1, ADD); drain("addi");
        setIn(6'h0D, 6'h00, 1); pushAlu(1, OR);  drain("ori");

        setIn(6'h04, 6'h00, 1); pushOneExec(2'b10, 0); drain("beq_taken");
        setIn(6'h04, 6'h00, 0); pushOneExec(2'b01, 0); drain("beq_not");
        setIn(6'h05, 6'h00, 1); pushOneExec(2'b01, 0); drain("bne_not");
        setIn(6'h05, 6'h00, 0); pushOneExec(2'b10, 0); drain("bne_taken");
        setIn(6'h02, 6'h3F, 1); pushOneExec(2'b00, 0); drain("j");
        setIn(6'h00, 6'h08, 0); pushOneExec(2'b11, 0); drain("jr");

        setIn(6'h2B, 6'h00, 0); pushLoadStore(0); drain("sw");
        setIn(6'h23, 6'h00, 0); pushLoadStore(1); drain("lw");

        setIn(6'h3E, 6'h00, 0); pushOneExec(2'b01, 1); drain("illegal_op");
        setIn(6'h00, 6'h3F, 0); pushOneExec(2'b01, 1); drain("illegal_funct");
        // Next instruction must start with a normal fetch after an illegal one
        setIn(6'h00, 6'h20, 0); pushAlu(0, ADD); drain("add_after_illegal");

        // HALT, then 20 more cycles parked with only oHalted high
        setIn(6'h3F, 6'h00, 0);
        pushFD();
        for (int i = 0; i < 21; i++) sb.push_back(ev(11'd0, 0, 0, 0, 0, 0, 0, 1));
        drain("halt");
        #3 RST = 1'b0;
        #1 check("reset_after_halt", 18'd0);
        #1 RST = 1'b1;

        // LW interrupted by reset in the first MEM cycle
        setIn(6'h23, 6'h00, 0);
        pushFD();
        sb.push_back(ev(mc(2'b00, 0, 1, 0, ADD, 0, 0), 0, 0, 0, 0, 0, 0, 0));
        pushMem(1, 1);
        drain("lw_pre_reset");
        #3 RST = 1'b0;
        #1 check("reset_mid_mem", 18'd0);
        #1 RST = 1'b1;
        pushLoadStore(1); drain("lw_after_reset");

`ifdef MIPS_CTRL_PERF_CNT_EN
        force dut.retireCntQ = 32'hFFFF_FFFF;
        #1 release dut.retireCntQ;
        setIn(6'h02, 6'h00, 0); pushOneExec(2'b00, 0); drain("j_wrap");
        @(posedge CLK);
        #1;
        nAsserts++;
        assert (retireCount === 32'd0) else begin
            nFail++;
            $error("FAIL retire_count_wrap: observed %h expected %h", retireCount, 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
